// File: rtl/gray_counter.sv
// Gray-code counter with a sticky wrap flag; registered Gray output, one bit flips per step.
// Optional feature: define GRAY_DOWN_EN to add the Down port (decrement, underflow also sets Overflow).
module gray_counter #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
`ifdef GRAY_DOWN_EN
  input  logic             Down,
`endif
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] LAST = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             wrap;

  // Gray value is encoded from the next binary count so the output flop
  // is driven directly, never re-decoded after the register.
  always_comb begin
    cnt_d  = cnt_q;
    gray_d = gray_q;
    ovf_d  = ovf_q;
    wrap   = 1'b0;
    if (En) begin
`ifdef GRAY_DOWN_EN
      if (Down) begin
        wrap  = (cnt_q == ZERO);
        cnt_d = cnt_q - ONE;
      end else begin
        wrap  = (cnt_q == LAST);
        cnt_d = cnt_q + ONE;
      end
`else
      wrap  = (cnt_q == LAST);
      cnt_d = cnt_q + ONE;
`endif
      gray_d = cnt_d ^ (cnt_d >> 1);
      ovf_d  = ovf_q | wrap;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Output   = gray_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomized + directed bench for gray_counter (WIDTH=3) against a count/lookup-table model.
module tb_gray_counter;
  localparam int W = 3;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         En = 1'b0;
  logic         Down = 1'b0;
  logic [W-1:0] Output;
  logic         Overflow;

  int checks = 0;
  int failures = 0;

  // Model: plain integer position in the sequence plus a sticky flag.
  int m_cnt = 0;
  int m_ovf = 0;
  int gseq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  gray_counter #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .En(En),
`ifdef GRAY_DOWN_EN
    .Down(Down),
`endif
    .Output(Output),
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic dn);
    logic [W-1:0] prev;
    @(negedge Clk);
    En   = en;
    Down = dn;
    prev = Output;
    @(posedge Clk);
    #1;
    if (en) begin
`ifdef GRAY_DOWN_EN
      if (dn) begin
        if (m_cnt == 0) m_ovf = 1;
        m_cnt = (m_cnt + 7) % 8;
      end else begin
        if (m_cnt == 7) m_ovf = 1;
        m_cnt = (m_cnt + 1) % 8;
      end
`else
      if (m_cnt == 7) m_ovf = 1;
      m_cnt = (m_cnt + 1) % 8;
`endif
    end
    chk("out", int'(Output), gseq[m_cnt]);
    chk("ovf", int'(Overflow), m_ovf);
    chk("onebit", $countones(prev ^ Output), en ? 1 : 0);
  endtask

  // Reset pulse placed mid-cycle; outputs must clear before any edge.
  task automatic async_reset(input int off);
    @(negedge Clk);
    #(off);
    Reset = 1'b1;
    #1;
    m_cnt = 0;
    m_ovf = 0;
    chk("rst_out", int'(Output), 0);
    chk("rst_ovf", int'(Overflow), 0);
    En = 1'b1;
    @(negedge Clk);
    chk("rst_hold_out", int'(Output), 0);
    chk("rst_hold_ovf", int'(Overflow), 0);
    Reset = 1'b0;
    En = 1'b0;
  endtask

  initial begin
    #1;
    chk("init_out", int'(Output), 0);
    chk("init_ovf", int'(Overflow), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Full up cycle, wrap, and 5 more codes.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("pre_wrap_out", int'(Output), 3'b100);
    chk("pre_wrap_ovf", int'(Overflow), 0);
    step(1'b1, 1'b0);
    chk("wrap_out", int'(Output), 0);
    chk("wrap_ovf", int'(Overflow), 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("post_wrap_out", int'(Output), 3'b111);

    // Enable gating from 011.
    async_reset(2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("at_011", int'(Output), 3'b011);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("held_010", int'(Output), 3'b010);
    step(1'b1, 1'b0);
    chk("after_110", int'(Output), 3'b110);

    // Reach 101 with Overflow set, then reset mid-cycle.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("at_101", int'(Output), 3'b101);
    chk("at_101_ovf", int'(Overflow), 1);
    async_reset(3);
    step(1'b1, 1'b0);
    chk("resume_001", int'(Output), 3'b001);

`ifdef GRAY_DOWN_EN
    async_reset(1);
    step(1'b1, 1'b1);
    chk("dn_100", int'(Output), 3'b100);
    chk("dn_ovf", int'(Overflow), 1);
    step(1'b1, 1'b1);
    chk("dn_101", int'(Output), 3'b101);
    step(1'b1, 1'b1);
    chk("dn_111", int'(Output), 3'b111);
`endif

    // Random enables/directions with occasional async resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset(int'($urandom_range(1, 4)));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
